// File: rtl/button_debounce.sv
// Two-flop synchronizer and tick-based debouncer for 4 push-buttons and 4 slide switches.
// Optional per-button auto-repeat is built when BUTTON_AUTO_REPEAT_EN is defined.
module button_debounce #(
    parameter int DEBOUNCE_TICKS = 200,
    parameter int REPEAT_DELAY   = 5000,
    parameter int REPEAT_PERIOD  = 1000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Tick,
    input  logic [3:0] Button,
    input  logic [3:0] Slide_Switch,
    output logic [3:0] Button_Level,
    output logic [3:0] Switch_Level,
    output logic [3:0] Button_Press,
    output logic       Switch_Change
);

    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255) begin : g_bad_debounce
        $error("DEBOUNCE_TICKS must be in 1..255");
    end
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 8191) begin : g_bad_delay
        $error("REPEAT_DELAY must be in 1..8191");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 8191) begin : g_bad_period
        $error("REPEAT_PERIOD must be in 1..8191");
    end

    localparam logic [7:0] DB_TGT = 8'(DEBOUNCE_TICKS);

    // Channel order: [3:0] buttons, [7:4] slide switches
    logic [7:0] sync_p0;
    logic [7:0] sync_p1;
    logic [7:0] stb_q;
    logic [7:0] stb_nxt;
    logic [7:0] cnt_q   [8];
    logic [7:0] cnt_nxt [8];
    logic [3:0] btn_lvl_d;
    logic [3:0] sw_lvl_d;
    logic [3:0] rep_hit;

    // Stage p0/p1: metastability synchronizer
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {Slide_Switch, Button};
            sync_p1 <= sync_p0;
        end
    end

    // Any agreeing tick throws away the partial count
    always_comb begin
        stb_nxt = stb_q;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (Tick) begin
                if (sync_p1[i] == stb_q[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt_q[i] + 8'd1 == DB_TGT) begin
                    cnt_nxt[i] = '0;
                    stb_nxt[i] = ~stb_q[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Stage: accepted levels, then edge pulses one cycle later
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stb_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            btn_lvl_d     <= '0;
            sw_lvl_d      <= '0;
            Button_Press  <= '0;
            Switch_Change <= 1'b0;
        end else begin
            stb_q <= stb_nxt;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_nxt[i];
            end
            btn_lvl_d     <= stb_q[3:0];
            sw_lvl_d      <= stb_q[7:4];
            Button_Press  <= (stb_q[3:0] & ~btn_lvl_d) | rep_hit;
            Switch_Change <= |(stb_q[7:4] ^ sw_lvl_d);
        end
    end

    assign Button_Level = stb_q[3:0];
    assign Switch_Level = stb_q[7:4];

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [12:0] RPT_DELAY  = 13'(REPEAT_DELAY);
    localparam logic [12:0] RPT_PERIOD = 13'(REPEAT_PERIOD);

    logic [12:0] hold_q [4];
    logic [3:0]  rep_phase_q;

    // Hold ticks count only while the level stays high through the tick; release clears
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
            rep_phase_q <= '0;
            rep_hit     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                rep_hit[i] <= 1'b0;
                if (!(stb_q[i] && stb_nxt[i])) begin
                    hold_q[i]      <= '0;
                    rep_phase_q[i] <= 1'b0;
                end else if (Tick) begin
                    if (hold_q[i] + 13'd1 == (rep_phase_q[i] ? RPT_PERIOD : RPT_DELAY)) begin
                        rep_hit[i]     <= 1'b1;
                        hold_q[i]      <= '0;
                        rep_phase_q[i] <= 1'b1;
                    end else begin
                        hold_q[i] <= hold_q[i] + 13'd1;
                    end
                end
            end
        end
    end
`else
    assign rep_hit = '0;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 200, is the number of consecutive Tick pulses a raw input must hold a new level before it is accepted (20 ms at 10 kHz); legal range 1..255.
REQ-002 Parameter REPEAT_DELAY, default 5000, is the number of Tick pulses a button is held before the first auto-repeat pulse; legal range 1..8191.
REQ-003 Parameter REPEAT_PERIOD, default 1000, is the number of Tick pulses between subsequent auto-repeat pulses; legal range 1..8191.
REQ-004 Port CLK, input, 1 bit: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port Tick, input, 1 bit: one-CLK-cycle sample-enable pulse (10 kHz divider output).
REQ-007 Port Button, input, 4 bits: raw, asynchronous, bouncing push-buttons, 1 = pressed.
REQ-008 Port Slide_Switch, input, 4 bits: raw, asynchronous, bouncing slide switches.
REQ-009 Port Button_Level, output, 4 bits: debounced button levels (feeds User_Input1).
REQ-010 Port Switch_Level, output, 4 bits: debounced switch levels (feeds User_Input0).
REQ-011 Port Button_Press, output, 4 bits: per-bit one-CLK pulse on accepted press or auto-repeat.
REQ-012 Port Switch_Change, output, 1 bit: one-CLK pulse when any Switch_Level bit changes.

Function
REQ-013 Each of the 8 raw inputs SHALL pass through its own two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a stable bit and an 8-bit counter; counter advances only on cycles where Tick=1.
REQ-015 On a Tick cycle, synchronized input equal to stable bit SHALL clear that counter to 0.
REQ-016 On a Tick cycle, synchronized input differing from stable bit SHALL increment the counter; when the incremented value equals DEBOUNCE_TICKS, stable bit SHALL toggle and counter SHALL clear in the same cycle.
REQ-017 Any single-Tick agreement during a bounce SHALL restart the count from 0 (no partial credit).
REQ-018 Latency from a clean raw edge to Level output: 2 CLK synchronizer cycles plus DEBOUNCE_TICKS Tick pulses; Level registers update in the CLK cycle of the qualifying Tick.
REQ-019 Button_Press[i] SHALL be high for exactly the CLK cycle after Button_Level[i] rises 0->1; releases SHALL produce no pulse.
REQ-020 Switch_Change SHALL be high for exactly the CLK cycle after any Switch_Level bit toggles; simultaneous toggles SHALL produce one pulse.
REQ-021 Channels SHALL be fully independent; simultaneous presses on several buttons SHALL pulse the corresponding Button_Press bits in the same cycle.
REQ-022 Tick held high continuously SHALL be legal and treated as a tick every CLK cycle.
REQ-023 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 Reset=1 SHALL asynchronously clear synchronizers, stable bits, all counters, Button_Level, Switch_Level, Button_Press, Switch_Change to 0.
REQ-025 Reset asserted mid-count SHALL discard the count; after release, an input already high SHALL require the full DEBOUNCE_TICKS again before acceptance.
REQ-026 Reset release SHALL be taken on the CLK edge; no output pulse SHALL be generated by reset itself.

Configuration
REQ-027 Macro BUTTON_AUTO_REPEAT_EN defined: each button SHALL have a 13-bit hold counter advancing on Tick while Button_Level[i]=1, emitting an extra Button_Press[i] pulse when it reaches REPEAT_DELAY and then every REPEAT_PERIOD Ticks, cleared on release or Reset.
REQ-028 Macro BUTTON_AUTO_REPEAT_EN undefined: hold counters SHALL not be built; Button_Press pulses only per REQ-019; REPEAT_DELAY and REPEAT_PERIOD SHALL be ignored.

Verification (DEBOUNCE_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, Tick every 4th CLK)
REQ-029 Button=0001 held clean -> Button_Level=0001 on 4th Tick after sync, Button_Press=0001 for one CLK next cycle, no further pulse without repeat.
REQ-030 Button[2] toggled 1,0,1,1,0 on successive Ticks then held 1 -> no change until 4 consecutive high Ticks; exactly one Button_Press[2] pulse.
REQ-031 Slide_Switch 0000->1010 simultaneously -> Switch_Level=1010 after 4 Ticks, single Switch_Change pulse; 1010->0000 -> second single pulse.
REQ-032 Button=1111 high, Reset pulsed after 2 Ticks -> all outputs 0 immediately; Level=1111 only 4 Ticks after release, one pulse on all bits.
REQ-033 With BUTTON_AUTO_REPEAT_EN, Button[0] held 20 Ticks after acceptance -> Button_Press[0] pulses at acceptance and hold Ticks 10, 13, 16, 19; none after release.
